// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - start/done handshake and operand/result bundle for serial_add_ctrl
// The sub signal exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin,
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin,
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - serial adder sequencer driving a 2-bit ripple slice over WIDTH/2 cycles
// Define SERIAL_ADD_SUB_EN to add the subtract path (a - b via ~b and carry-in 1).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  serial_add_ctrl_if.slave  bus
);
  localparam int NPAIRS = WIDTH / 2;
  localparam int CW     = $clog2(NPAIRS) + 1;
  localparam logic [CW-1:0] LAST = CW'(NPAIRS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_next, sum_q;
  logic [CW-1:0]    count;
  logic             carry;
  logic             busy_q, done_q, cout_q, ovf_q;
  logic             s0, s1, c1, c2;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

`ifdef SERIAL_ADD_SUB_EN
  assign b_load     = bus.sub ? ~bus.b : bus.b;
  assign carry_load = bus.sub | bus.cin;
`else
  assign b_load     = bus.b;
  assign carry_load = bus.cin;
`endif

  full_adder fa0 (.a(a_q[0]), .b(b_q[0]), .ci(carry), .s(s0), .co(c1));
  full_adder fa1 (.a(a_q[1]), .b(b_q[1]), .ci(c1),    .s(s1), .co(c2));

  // Slice sum enters from the top so the LS pair ends at bit 0 after the last shift.
  always_comb begin
    res_next            = res_q >> 2;
    res_next[WIDTH-1]   = s1;
    res_next[WIDTH-2]   = s0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      carry  <= 1'b0;
      count  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q    <= bus.a;
            b_q    <= b_load;
            carry  <= carry_load;
            count  <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          a_q   <= a_q >> 2;
          b_q   <= b_q >> 2;
          carry <= c2;
          res_q <= res_next;
          count <= count + CW'(1);
          // c1 here is the carry into the MSB, giving signed overflow directly.
          if (count == LAST) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            sum_q  <= res_next;
            cout_q <= c2;
            ovf_q  <= c1 ^ c2;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed and random checks for serial_add_ctrl (WIDTH=8)
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  serial_add_ctrl_if #(.WIDTH(8)) bus ();
  serial_add_ctrl #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub, input logic [7:0] esum,
                        input logic ecout, input logic eovf);
    int cycles;
    int busy_cnt;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub   = sub;
`else
    if (sub) bus.cin = cin;
`endif
    @(negedge clk);
    bus.start = 1'b0;
    cycles    = 0;
    busy_cnt  = 0;
    while (!bus.done && cycles < 20) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      cycles++;
    end
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_busy_cycles"}, busy_cnt, 32'd4);
    chk({tag, "_sum"}, 32'(bus.sum), 32'(esum));
    chk({tag, "_cout"}, 32'(bus.cout), 32'(ecout));
    chk({tag, "_ovf"}, 32'(bus.overflow), 32'(eovf));
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = 1'b0;
`endif
  endtask

  task automatic check_pulse_end(input string tag, input logic [7:0] esum);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "_sum_hold"}, 32'(bus.sum), 32'(esum));
  endtask

  initial begin
    logic [8:0] tot;
    logic [7:0] ra, rb;
    logic       rc;
    int         done_cnt;
    int         cycles;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("add5a3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
    check_pulse_end("add5a3c", 8'h96);
    run_op("addff01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check_pulse_end("addff01", 8'h00);
    run_op("add7f00c", 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);
    check_pulse_end("add7f00c", 8'h80);

    // start held through RUN with changing operands, still high in DONE
    bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0;
    @(negedge clk);
    bus.a = 8'h01; bus.b = 8'h02; bus.cin = 1'b1;
    cycles = 0;
    while (!bus.done && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    chk("hold_first_done", 32'(bus.done), 32'd1);
    chk("hold_first_sum", 32'(bus.sum), 32'h46);
    @(negedge clk);
    chk("hold_b2b_busy", 32'(bus.busy), 32'd1);
    chk("hold_b2b_done_low", 32'(bus.done), 32'd0);
    bus.start = 1'b0;
    cycles = 0;
    while (!bus.done && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    chk("hold_second_done", 32'(bus.done), 32'd1);
    chk("hold_second_sum", 32'(bus.sum), 32'h04);
    chk("hold_second_cout", 32'(bus.cout), 32'd0);
    @(negedge clk);

    // reset during the second RUN cycle aborts with no done
    bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_sum", 32'(bus.sum), 32'd0);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done) done_cnt++;
      @(negedge clk);
    end
    chk("abort_no_done", done_cnt, 32'd0);

`ifdef SERIAL_ADD_SUB_EN
    run_op("sub1020", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
    check_pulse_end("sub1020", 8'hF0);
    run_op("sub8001", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    check_pulse_end("sub8001", 8'h7F);
`endif

    for (int i = 0; i < 1000; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rc  = 1'($urandom);
      tot = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      run_op("rand", ra, rb, rc, 1'b0, tot[7:0], tot[8],
             (ra[7] == rb[7]) && (tot[7] != ra[7]));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
